// File: rtl/fpu_mul_pipe.sv
// fpu_mul_pipe: three-stage pipelined floating-point multiplier.
// S1 unpack/classify, S2 significand multiply, S3 normalise/round/pack.
// Subnormal inputs are treated as zero and tiny results flush to zero.
// One global advance signal moves every stage together; in_ready is the
// only combinational output.
module fpu_mul_pipe #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int TAG_WIDTH      = 4,
    localparam int W             = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         operand_a,
    input  logic [W-1:0]         operand_b,
    input  logic                 round_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [3:0]           flags,
    output logic                 exception
);
    localparam int E  = EXPONENT_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int EW = E + 2;
    localparam int PW = 2 * M + 2;
    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (E - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << E) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    logic       advance;
    logic [3:1] vld_pipe;

    assign advance   = !vld_pipe[3] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[3];
    assign exception = |flags;

    // ---------------- S1: unpack / classify ----------------
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, sign_in;
    logic              spec_in, inv_in;
    logic [W-1:0]      spec_res_in;
    logic signed [EW-1:0] exp_sum_in;

    assign ea      = operand_a[W-2:M];
    assign eb      = operand_b[W-2:M];
    assign fa      = operand_a[M-1:0];
    assign fb      = operand_b[M-1:0];
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (&ea) && (fa == '0);
    assign b_inf   = (&eb) && (fb == '0);
    assign a_nan   = (&ea) && (fa != '0);
    assign b_nan   = (&eb) && (fb != '0);
    assign a_snan  = a_nan && !fa[M-1];
    assign b_snan  = b_nan && !fb[M-1];
    assign sign_in = operand_a[W-1] ^ operand_b[W-1];
    assign exp_sum_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    // Special-operand results bypass the arithmetic, NaN taking precedence
    always_comb begin
        spec_in     = 1'b0;
        inv_in      = 1'b0;
        spec_res_in = '0;
        if (a_nan || b_nan) begin
            spec_in     = 1'b1;
            spec_res_in = QNAN;
            inv_in      = a_snan || b_snan;
        end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            spec_in     = 1'b1;
            spec_res_in = QNAN;
            inv_in      = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_in     = 1'b1;
            spec_res_in = {sign_in, {E{1'b1}}, {M{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_in     = 1'b1;
            spec_res_in = {sign_in, {(W-1){1'b0}}};
        end
    end

    // Stage valid bits shift together on advance; bubbles shift too
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (advance)
            vld_pipe <= {vld_pipe[2:1], in_valid};
    end

    logic                 s1_sign, s1_spec, s1_inv, s1_rm;
    logic [W-1:0]         s1_spec_res;
    logic signed [EW-1:0] s1_exp;
    logic [M:0]           s1_ma, s1_mb;
    logic [TAG_WIDTH-1:0] s1_tag;

    // S1 payload registers
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign     <= sign_in;
            s1_spec     <= spec_in;
            s1_inv      <= inv_in;
            s1_rm       <= round_mode;
            s1_spec_res <= spec_res_in;
            s1_exp      <= exp_sum_in;
            s1_ma       <= {1'b1, fa};
            s1_mb       <= {1'b1, fb};
            s1_tag      <= in_tag;
        end
    end

    // ---------------- S2: significand multiply ----------------
    logic                 s2_sign, s2_spec, s2_inv, s2_rm;
    logic [W-1:0]         s2_spec_res;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;
    logic [TAG_WIDTH-1:0] s2_tag;

    // S2 payload registers, product of the two hidden-bit significands
    always_ff @(posedge clk) begin
        if (advance) begin
            s2_sign     <= s1_sign;
            s2_spec     <= s1_spec;
            s2_inv      <= s1_inv;
            s2_rm       <= s1_rm;
            s2_spec_res <= s1_spec_res;
            s2_exp      <= s1_exp;
            s2_prod     <= PW'(s1_ma) * PW'(s1_mb);
            s2_tag      <= s1_tag;
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic                 msb, guard, sticky, inc;
    logic [M-1:0]         frac;
    logic [M:0]           frac_r;
    logic signed [EW-1:0] exp_n, exp_r;
    logic [W-1:0]         res_nx;
    logic [3:0]           flg_nx;

    assign msb    = s2_prod[PW-1];
    assign frac   = msb ? s2_prod[2*M:M+1] : s2_prod[2*M-1:M];
    assign guard  = msb ? s2_prod[M] : s2_prod[M-1];
    assign sticky = msb ? |s2_prod[M-1:0] : |s2_prod[M-2:0];
    assign inc    = !s2_rm && guard && (sticky || frac[0]);
    assign frac_r = {1'b0, frac} + {{M{1'b0}}, inc};
    assign exp_n  = s2_exp + $signed({{(EW-1){1'b0}}, msb});
    // A rounding carry leaves frac_r[M-1:0] at zero, so only the exponent moves
    assign exp_r  = exp_n + $signed({{(EW-1){1'b0}}, frac_r[M]});

    // Pick special, overflow, flush-to-zero or normal packed result
    always_comb begin
        res_nx = {s2_sign, exp_r[E-1:0], frac_r[M-1:0]};
        flg_nx = {3'b000, guard || sticky};
        if (s2_spec) begin
            res_nx = s2_spec_res;
            flg_nx = {s2_inv, 3'b000};
        end else if (exp_r >= EXP_MAX) begin
            res_nx = s2_rm ? {s2_sign, {(E-1){1'b1}}, 1'b0, {M{1'b1}}}
                           : {s2_sign, {E{1'b1}}, {M{1'b0}}};
            flg_nx = 4'b0101;
        end else if (exp_r <= EXP_ZERO) begin
            res_nx = {s2_sign, {(W-1){1'b0}}};
            flg_nx = 4'b0011;
        end
    end

    // Output registers; held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            out_tag <= '0;
            flags   <= '0;
        end else if (advance) begin
            result  <= res_nx;
            out_tag <= s2_tag;
            flags   <= flg_nx;
        end
    end
endmodule

// File: tb/tb_fpu_mul_pipe.sv
// tb_fpu_mul_pipe: scoreboard bench for fpu_mul_pipe (binary32 default).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and
// compares whenever a result is handed off.
module tb_fpu_mul_pipe;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, round_mode = 1'b0;
    logic [31:0] operand_a = '0, operand_b = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid, exception;
    logic [31:0] result;
    logic [3:0]  out_tag, flags;

    fpu_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .round_mode(round_mode),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag), .flags(flags), .exception(exception)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [3:0]  flg;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0, n_fail = 0, cyc = 0;
    bit   lat_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Present one op, wait (bounded) for acceptance, record the expectation
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic rm,
                         input logic [3:0] tag, input logic [31:0] res,
                         input logic [3:0] flg, input bit track);
        int n = 0;
        exp_t x;
        operand_a = a; operand_b = b; round_mode = rm; in_tag = tag; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: tag %0d never accepted, expected in_ready=1", tag);
        end else if (track) begin
            x.res = res; x.tag = tag; x.flg = flg; x.acc = cyc; x.lat = lat_chk;
            q.push_back(x);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: handshake rule, stall hold, and scoreboard pop on completion
    bit          stalled = 1'b0;
    logic [31:0] h_res;
    logic [3:0]  h_tag, h_flg;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            chk("in_ready_rule", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
            if (stalled) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_result", result, h_res);
                chk("hold_tag", {28'b0, out_tag}, {28'b0, h_tag});
                chk("hold_flags", {28'b0, flags}, {28'b0, h_flg});
            end
            stalled = out_valid && !out_ready;
            h_res = result; h_tag = out_tag; h_flg = flags;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_out: got result %h tag %0d, expected no output",
                             result, out_tag);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("out_tag", {28'b0, out_tag}, {28'b0, e.tag});
                    chk("flags", {28'b0, flags}, {28'b0, e.flg});
                    chk("exception", {31'b0, exception}, {31'b0, |e.flg});
                    if (e.lat) chk("latency", cyc - e.acc, 32'd3);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_out_tag", {28'b0, out_tag}, 32'd0);
        chk("rst_flags", {28'b0, flags}, 32'd0);
        chk("rst_exception", {31'b0, exception}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed vectors, back to back with out_ready held high
        issue(32'h40000000, 32'h40000000, 1'b0, 4'd3,  32'h40800000, 4'b0000, 1'b1);
        issue(32'h40400000, 32'h3F800001, 1'b0, 4'd1,  32'h40400002, 4'b0001, 1'b1);
        issue(32'h40400000, 32'h3F800001, 1'b1, 4'd2,  32'h40400001, 4'b0001, 1'b1);
        issue(32'h00000000, 32'h7F800000, 1'b0, 4'd4,  32'h7FC00000, 4'b1000, 1'b1);
        issue(32'h7F800001, 32'h3F800000, 1'b0, 4'd5,  32'h7FC00000, 4'b1000, 1'b1);
        issue(32'h7FC00000, 32'h3F800000, 1'b0, 4'd6,  32'h7FC00000, 4'b0000, 1'b1);
        issue(32'hFF800000, 32'h40000000, 1'b0, 4'd7,  32'hFF800000, 4'b0000, 1'b1);
        issue(32'h80000000, 32'h40000000, 1'b0, 4'd8,  32'h80000000, 4'b0000, 1'b1);
        issue(32'h00000001, 32'h7F800000, 1'b0, 4'd9,  32'h7FC00000, 4'b1000, 1'b1);
        issue(32'h7F000000, 32'h7F000000, 1'b0, 4'd10, 32'h7F800000, 4'b0101, 1'b1);
        issue(32'h7F000000, 32'h7F000000, 1'b1, 4'd11, 32'h7F7FFFFF, 4'b0101, 1'b1);
        issue(32'h00800000, 32'h00800000, 1'b0, 4'd12, 32'h00000000, 4'b0011, 1'b1);
        issue(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 4'd13, 32'h407FFFFE, 4'b0001, 1'b1);
        issue(32'h3FAAAAAB, 32'h3FC00000, 1'b0, 4'd14, 32'h40000000, 4'b0001, 1'b1);
        drain();

        // Backpressure: tags 0..5 back to back, consumer stalls for 5 cycles
        lat_chk = 1'b0;
        fork
            begin
                issue(32'h40000000, 32'h40000000, 1'b0, 4'd0, 32'h40800000, 4'b0000, 1'b1);
                issue(32'h40400000, 32'h3F800001, 1'b0, 4'd1, 32'h40400002, 4'b0001, 1'b1);
                issue(32'h40400000, 32'h3F800001, 1'b1, 4'd2, 32'h40400001, 4'b0001, 1'b1);
                issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd3, 32'h3F800000, 4'b0000, 1'b1);
                issue(32'h80000000, 32'h40000000, 1'b0, 4'd4, 32'h80000000, 4'b0000, 1'b1);
                issue(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 4'd5, 32'h407FFFFE, 4'b0001, 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Reset with three ops in flight and the consumer stalled
        out_ready = 1'b0;
        issue(32'h40000000, 32'h40000000, 1'b0, 4'd1, 32'h0, 4'b0, 1'b0);
        issue(32'h40400000, 32'h3F800001, 1'b0, 4'd2, 32'h0, 4'b0, 1'b0);
        issue(32'h7F000000, 32'h7F000000, 1'b0, 4'd3, 32'h0, 4'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_flags", {28'b0, flags}, 32'd0);
        chk("midrst_exception", {31'b0, exception}, 32'd0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        issue(32'h3F800000, 32'h40000000, 1'b0, 4'd9, 32'h40000000, 4'b0000, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
